// File: rtl/fetch_pc_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_stage_pkg
// Purpose  : Shared widths, NOP encoding and IF/ID entry type for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pc_stage_pkg;

    localparam int unsigned C_WORD_WIDTH  = 64;
    localparam int unsigned C_INSTR_WIDTH = 32;

    typedef logic [C_WORD_WIDTH-1:0]  word_t;
    typedef logic [C_INSTR_WIDTH-1:0] instr_t;

    localparam instr_t C_NOP_INSTR = 32'hD503201F;
    localparam word_t  C_PC_STEP   = 64'd4;

    typedef struct packed {
        word_t  pc;
        instr_t instr;
        logic   valid;
    } if_id_t;

    // Instructions are word aligned; the low two target bits are discarded.
    function automatic word_t align_word(input word_t addr);
        return addr & ~word_t'(2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_stage_if
// Purpose  : Control, instruction-memory and IF/ID signals of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_stage_if;
    import fetch_pc_stage_pkg::*;

    logic   stall;
    logic   flush;
    logic   branch_taken;
    word_t  branch_target;
    word_t  imem_addr;
    instr_t imem_data;
    word_t  pc_out;
    instr_t instr_out;
    logic   valid_out;

    modport master (
        input  stall, flush, branch_taken, branch_target, imem_data,
        output imem_addr, pc_out, instr_out, valid_out
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, imem_data,
        input  imem_addr, pc_out, instr_out, valid_out
    );

endinterface
`default_nettype wire

// File: rtl/fetch_pc_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_stage_if_id_reg
// Purpose  : Pipeline register holding pc/instr/valid with reset > bubble > stall priority.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_stage_if_id_reg
    import fetch_pc_stage_pkg::*;
#(
    parameter instr_t NOP_INSTR = C_NOP_INSTR
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic stall,
    input  wire logic bubble,
    input  wire word_t  pc_in,
    input  wire instr_t instr_in,
    output if_id_t     entry
);

    if_id_t r_entry;

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            r_entry <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (!stall) begin
            r_entry <= '{pc: pc_in, instr: instr_in, valid: 1'b1};
        end
    end

    assign entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_stage
// Purpose  : Program counter with redirect/stall and IF/ID register feeding decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter word_t  RESET_PC  = 64'h0,
    parameter instr_t NOP_INSTR = C_NOP_INSTR
) (
    input  wire logic        clk,
    input  wire logic        reset,
    fetch_pc_stage_if.master bus
);

    word_t  r_pc;
    word_t  w_pc_plus4;
    if_id_t w_entry;

    // Wraps modulo 2^64 by construction.
    assign w_pc_plus4 = r_pc + C_PC_STEP;

    // A redirect outranks stall so a resolved branch is never dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (bus.branch_taken) begin
            r_pc <= align_word(bus.branch_target);
        end else if (!bus.stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    fetch_pc_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .stall    (bus.stall),
        .bubble   (bus.flush | bus.branch_taken),
        .pc_in    (r_pc),
        .instr_in (bus.imem_data),
        .entry    (w_entry)
    );

    assign bus.imem_addr = r_pc;
    assign bus.pc_out    = w_entry.pc;
    assign bus.instr_out = w_entry.instr;
    assign bus.valid_out = w_entry.valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_stage
// Purpose  : Directed bench for fetch_pc_stage at RESET_PC 0 and near the top of memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_stage;
    import fetch_pc_stage_pkg::*;

    localparam word_t  C_HI_RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam instr_t C_NOP         = 32'hD503201F;

    logic clk;
    logic rst;
    logic rst_hi;
    int   n_checks;
    int   n_fail;

    fetch_pc_stage_if bus_lo ();
    fetch_pc_stage_if bus_hi ();

    fetch_pc_stage #(.RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_lo.master)
    );

    fetch_pc_stage #(.RESET_PC(C_HI_RESET_PC)) dut_hi (
        .clk   (clk),
        .reset (rst_hi),
        .bus   (bus_hi.master)
    );

    // Instruction memory model: distinct word per address, 8B020020 at address 0.
    function automatic instr_t mem(input word_t a);
        return 32'h8B020020 ^ a[31:0];
    endfunction

    assign bus_lo.imem_data = mem(bus_lo.imem_addr);
    assign bus_hi.imem_data = mem(bus_hi.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_lo(input string tag, input word_t addr, input word_t pc, input logic valid);
        check({tag, ".addr"},  bus_lo.imem_addr, addr);
        check({tag, ".pc"},    bus_lo.pc_out, pc);
        check({tag, ".valid"}, word_t'(bus_lo.valid_out), word_t'(valid));
        check({tag, ".instr"}, word_t'(bus_lo.instr_out), word_t'(valid ? mem(pc) : C_NOP));
    endtask

    task automatic chk_hi(input string tag, input word_t addr, input word_t pc, input logic valid);
        check({tag, ".addr"},  bus_hi.imem_addr, addr);
        check({tag, ".pc"},    bus_hi.pc_out, pc);
        check({tag, ".valid"}, word_t'(bus_hi.valid_out), word_t'(valid));
        check({tag, ".instr"}, word_t'(bus_hi.instr_out), word_t'(valid ? mem(pc) : C_NOP));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        rst_hi = 1'b1;
        bus_lo.stall = 1'b0; bus_lo.flush = 1'b0;
        bus_lo.branch_taken = 1'b0; bus_lo.branch_target = '0;
        bus_hi.stall = 1'b0; bus_hi.flush = 1'b0;
        bus_hi.branch_taken = 1'b0; bus_hi.branch_target = '0;

        tick();
        tick();
        chk_lo("reset", 64'h0, 64'h0, 1'b0);

        // Free run
        rst = 1'b0;
        check("first_addr", bus_lo.imem_addr, 64'h0);
        tick(); chk_lo("run1", 64'h4, 64'h0, 1'b1);
        tick(); chk_lo("run2", 64'h8, 64'h4, 1'b1);
        tick(); chk_lo("run3", 64'hC, 64'h8, 1'b1);
        tick(); chk_lo("run4", 64'h10, 64'hC, 1'b1);

        // Redirect to unaligned target
        bus_lo.branch_taken = 1'b1; bus_lo.branch_target = 64'h103;
        tick(); chk_lo("br_bubble", 64'h100, 64'h0, 1'b0);
        bus_lo.branch_taken = 1'b0;
        tick(); chk_lo("br_target", 64'h104, 64'h100, 1'b1);

        // Reach pc=0x20 with IF/ID holding 0x1C
        bus_lo.branch_taken = 1'b1; bus_lo.branch_target = 64'h18;
        tick(); chk_lo("to18", 64'h18, 64'h0, 1'b0);
        bus_lo.branch_taken = 1'b0;
        tick(); chk_lo("to1c", 64'h1C, 64'h18, 1'b1);
        tick(); chk_lo("to20", 64'h20, 64'h1C, 1'b1);

        // Three-cycle stall
        bus_lo.stall = 1'b1;
        tick(); chk_lo("stall1", 64'h20, 64'h1C, 1'b1);
        tick(); chk_lo("stall2", 64'h20, 64'h1C, 1'b1);
        tick(); chk_lo("stall3", 64'h20, 64'h1C, 1'b1);
        bus_lo.stall = 1'b0;
        tick(); chk_lo("resume1", 64'h24, 64'h20, 1'b1);
        tick(); chk_lo("resume2", 64'h28, 64'h24, 1'b1);

        // Branch overrides stall
        bus_lo.stall = 1'b1;
        bus_lo.branch_taken = 1'b1; bus_lo.branch_target = 64'h200;
        tick(); chk_lo("stall_br", 64'h200, 64'h0, 1'b0);
        bus_lo.stall = 1'b0; bus_lo.branch_taken = 1'b0;
        tick(); chk_lo("stall_br_tgt", 64'h204, 64'h200, 1'b1);

        // Flush alone at pc=0x40
        bus_lo.branch_taken = 1'b1; bus_lo.branch_target = 64'h40;
        tick(); chk_lo("to40", 64'h40, 64'h0, 1'b0);
        bus_lo.branch_taken = 1'b0;
        bus_lo.flush = 1'b1;
        tick(); chk_lo("flush", 64'h44, 64'h0, 1'b0);
        bus_lo.flush = 1'b0;
        tick(); chk_lo("post_flush", 64'h48, 64'h44, 1'b1);

        // Flush with stall: PC holds, IF/ID bubbles
        bus_lo.flush = 1'b1; bus_lo.stall = 1'b1;
        tick(); chk_lo("flush_stall", 64'h48, 64'h0, 1'b0);
        bus_lo.flush = 1'b0; bus_lo.stall = 1'b0;
        tick(); chk_lo("post_fs", 64'h4C, 64'h48, 1'b1);

        // Reset during redirect wins
        rst = 1'b1;
        bus_lo.branch_taken = 1'b1; bus_lo.branch_target = 64'h300;
        tick(); chk_lo("rst_br", 64'h0, 64'h0, 1'b0);
        rst = 1'b0; bus_lo.branch_taken = 1'b0;
        tick(); chk_lo("rst_br_run", 64'h4, 64'h0, 1'b1);

        // High reset vector with wrap-around
        rst_hi = 1'b0;
        check("hi_first", bus_hi.imem_addr, C_HI_RESET_PC);
        tick(); chk_hi("hi1", 64'hFFFF_FFFF_FFFF_FFFC, C_HI_RESET_PC, 1'b1);
        tick(); chk_hi("hi_wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        tick(); chk_hi("hi3", 64'h4, 64'h0, 1'b1);

        // Reset during stall
        bus_hi.stall = 1'b1;
        tick(); chk_hi("hi_stall", 64'h4, 64'h0, 1'b1);
        rst_hi = 1'b1;
        tick(); chk_hi("hi_rst_stall", C_HI_RESET_PC, 64'h0, 1'b0);
        rst_hi = 1'b0; bus_hi.stall = 1'b0;
        tick(); chk_hi("hi_rerun", 64'hFFFF_FFFF_FFFF_FFFC, C_HI_RESET_PC, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Fetch-stage front end of the ARMv8 pipeline: holds the program counter, advances it by 4 each cycle or redirects it to a branch target, drives the instruction-memory address, and registers the fetched instruction with its PC into the IF/ID pipeline register for decode. Sits between the branch-resolution logic (upstream, in execute/memory) and the decode stage (downstream). Supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'hD503201F, ARMv8 NOP inserted into IF/ID on reset/flush.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and IF/ID contents.
- flush  in  1  squash IF/ID contents (bubble).
- branch_taken  in  1  redirect PC this cycle.
- branch_target  in  `WORD  redirect address.
- imem_addr  out  `WORD  instruction-memory address (= current PC).
- imem_data  in  32  instruction at imem_addr, combinational read.
- pc_out  out  `WORD  IF/ID registered PC.
- instr_out  out  32  IF/ID registered instruction.
- valid_out  out  1  IF/ID entry holds a real instruction.

## Operation
- Internal PC register `pc`; imem_addr = pc (combinational).
- PC update priority per rising edge: reset → RESET_PC; else branch_taken → {branch_target[63:2], 2'b00}; else stall → hold; else pc + 4.
- PC + 4 is `WORD-bit unsigned, modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 → 0, no flag.
- IF/ID update priority: reset → pc_out=0, instr_out=NOP_INSTR, valid_out=0; else flush or branch_taken → pc_out=0, instr_out=NOP_INSTR, valid_out=0; else stall → hold all three; else pc_out ← pc, instr_out ← imem_data, valid_out ← 1.
- branch_taken overrides stall for both PC and IF/ID (redirect never lost).
- flush without branch_taken: PC follows stall/increment rule normally.
- No FSM beyond valid bit; valid_out is effectively a 2-state (bubble/valid) register.

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, pc_out=0, instr_out=NOP_INSTR, valid_out=0.
- First cycle after reset deasserts: imem_addr=RESET_PC; next edge: pc_out=RESET_PC, valid_out=1.
- Fetch latency: address presented in cycle n → IF/ID outputs valid in cycle n+1.
- Redirect: branch_taken asserted in cycle n → imem_addr=target in n+1, IF/ID bubble in n+1, target instruction in IF/ID in n+2 (one-cycle penalty).
- Stall held k cycles → PC and IF/ID frozen exactly k cycles; resume increments from held PC, no skipped or duplicated fetch.
- Reset asserted mid-stall or mid-redirect: reset wins same edge.
- All outputs registered except imem_addr (direct from pc register, no combinational path from inputs).

## Structure
- `WORD from definitions.vh; add `INSTR_WIDTH (32) and `NOP_INSTR there as shared constants.
- One sub-module natural: if_id_reg (pc/instr/valid register with stall/flush/reset priority), reused shape for later pipeline registers.
- PC+4 computed inline in top; PC register in top.

## Test plan
- Reset then run free, imem_data = 32'h8B020020 constant → imem_addr 0,4,8,12; valid_out 0 then 1; pc_out lags imem_addr by one cycle.
- At pc=0x10, branch_taken=1, branch_target=0x103 → imem_addr=0x100 next cycle; valid_out=0, instr_out=NOP_INSTR one cycle; then pc_out=0x100, valid_out=1.
- At pc=0x20, stall=1 for 3 cycles → imem_addr and IF/ID held at 0x20/0x1C for 3 cycles; then imem_addr=0x24.
- stall=1 and branch_taken=1 same cycle, target 0x200 → imem_addr=0x200 next cycle, IF/ID bubble.
- flush=1 alone at pc=0x40 → valid_out=0, instr_out=NOP_INSTR next cycle, imem_addr=0x44.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 → imem_addr …FFF8, …FFFC, 0x0; reset asserted during stall → all outputs return to reset values next edge.
